// File: rtl/ps2_keyboard_rx_if.sv
// Key-code and raw-byte outputs of the PS/2 keyboard receiver.
// The receiver drives the master side; the SOPC PIO side uses the slave side.
interface ps2_keyboard_rx_if;
    logic [7:0] key_code;
    logic       key_event;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    modport master (
        output key_code,
        output key_event,
        output rx_byte,
        output rx_valid,
        output frame_err
    );

    modport slave (
        input key_code,
        input key_event,
        input rx_byte,
        input rx_valid,
        input frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit deframing, scan-code-set-2 held-key decode.
// Define PS2_RX_EXTENDED_EN to map E0-prefixed codes to {1'b1, c[6:0]} instead of discarding them.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data=0 on a clock fall)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, then publishing or flagging the byte
module ps2_keyboard_rx #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    ps2_keyboard_rx_if.master   kb
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          filt_lvl_q, filt_lvl_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    logic          brk_q, brk_d, ext_q, ext_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_event_q, key_event_d;
    logic [7:0]    code;
    logic          code_ok;

    // Idle PS/2 lines are high, so the synchronisers come out of reset at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    always_comb begin
        filt_lvl_d = filt_lvl_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_sync_q != filt_lvl_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_lvl_d = clk_sync_q;
                fall_d     = filt_lvl_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_lvl_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_lvl_q <= filt_lvl_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    assign timeout = (state_q != S_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // A fall strobe takes precedence over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        if (fall_q) begin
            case (state_q)
                S_IDLE:   if (!dat_sync_q) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (fall_q || state_q == S_IDLE) to_cnt_d = '0;
        else if (timeout)                to_cnt_d = to_cnt_q;
        else                             to_cnt_d = to_cnt_q + 1'b1;

        if (fall_q) begin
            case (state_q)
                S_IDLE: bit_cnt_d = 3'd0;
                S_DATA: begin
                    shift_d = {dat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q != 3'd7) bit_cnt_d = bit_cnt_q + 3'd1;
                end
                S_PARITY: par_d = dat_sync_q;
                S_STOP: begin
                    if (dat_sync_q && (^{shift_q, par_q})) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PS2_RX_EXTENDED_EN
    assign code    = ext_q ? {1'b1, rx_byte_q[6:0]} : rx_byte_q;
    assign code_ok = 1'b1;
`else
    assign code    = rx_byte_q;
    assign code_ok = ~ext_q;
`endif

    // Last-key priority: a make always overwrites; a break only clears its own key.
    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        key_code_d  = key_code_q;
        key_event_d = 1'b0;
        if (frame_err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_valid_q) begin
            if (rx_byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (code_ok) begin
                    if (brk_q) begin
                        if (code == key_code_q) begin
                            key_code_d  = 8'h00;
                            key_event_d = 1'b1;
                        end
                    end else begin
                        key_code_d  = code;
                        key_event_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            key_code_q  <= '0;
            key_event_q <= 1'b0;
        end else begin
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            key_code_q  <= key_code_d;
            key_event_q <= key_event_d;
        end
    end

    assign kb.key_code  = key_code_q;
    assign kb.key_event = key_event_q;
    assign kb.rx_byte   = rx_byte_q;
    assign kb.rx_valid  = rx_valid_q;
    assign kb.frame_err = frame_err_q;
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receive-only PS/2 keyboard front end that produces the 8-bit key code consumed by the SOPC keyboard PIO input (`pio_keyboard_external_connection_export`). It synchronises and filters the PS/2 clock and data lines and deframes 11-bit frames: start, 8 data bits LSB first, odd parity, stop. It then decodes scan-code-set-2 make/break/extended sequences into a held-key code. It sits between the DE2-115 PS/2 pins and the SOPC top.

## Interface
- `FILT_LEN`, default 8: cycles `ps2_clk` must be stable before a level change is accepted.
- `TIMEOUT_CYC`, default 100000: idle-clock cycles (2 ms at 50 MHz) that abort a partial frame.
- `clk` input 1: system clock, 50 MHz.
- `reset_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_dat` input 1: raw PS/2 data pin, asynchronous.
- `key_code` output 8: currently held key code, 0x00 when no key is held; drives the keyboard PIO.
- `key_event` output 1: one-cycle pulse whenever `key_code` is written, on make or on a matching break.
- `rx_byte` output 8: last correctly received raw byte.
- `rx_valid` output 1: one-cycle pulse when `rx_byte` updates.
- `frame_err` output 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_dat` each pass through a 2-FF synchroniser.
  - The synchronised clock feeds a stability filter: the filtered level changes only after `FILT_LEN` consecutive equal samples.
  - A filtered 1->0 transition is the "fall" strobe, one cycle wide.
  - Data is sampled from the synchronised data line on the fall strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with the bit count cleared. On fall with data=1 (bad start), stay in IDLE with no error.
  - DATA: on each fall, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, go to IDLE.
    - Frame good when stop=1 and (popcount(data)+parity) is odd: `rx_byte`<=data, `rx_valid` pulses.
    - Otherwise `frame_err` pulses and the byte is discarded.
- Timeout:
  - The counter (`$clog2(TIMEOUT_CYC)` bits) clears on every fall and in IDLE.
  - In any non-IDLE state, reaching `TIMEOUT_CYC-1` forces IDLE, pulses `frame_err` and saturates the counter.
- Decoder, acting on `rx_valid`:
  - 0xF0: set the `brk` flag.
  - 0xE0: set the `ext` flag.
  - Any other byte `c`:
    - If `brk` is set: when the formed code equals `key_code`, write `key_code`<=0x00 and pulse `key_event`. Otherwise make no change and no event.
    - If `brk` is clear: `key_code`<=formed code and pulse `key_event`. This is last-key priority; typematic repeats rewrite the same value and pulse again.
    - Clear both `brk` and `ext` after any non-prefix byte.
  - `brk` and `ext` are independent flags, so both E0 F0 xx and F0 E0 xx are accepted.
  - Any `frame_err` clears `brk` and `ext`; `key_code` is retained.
- Arithmetic: parity is an XOR reduction; the bit counter is 3 bits and does not wrap beyond 7 inside DATA.

## Timing
- Reset values: `key_code`=0x00, `rx_byte`=0x00, `key_event`=0, `rx_valid`=0, `frame_err`=0. FSM in IDLE, flags clear, filter level=1, counters 0.
- Fall strobe: `2+FILT_LEN` cycles after the pin edge.
- Latency from the stop-bit fall strobe:
  - `rx_valid` / `frame_err`: next cycle.
  - `key_code` / `key_event`: one cycle after `rx_valid`.
- A timeout and a fall strobe in the same cycle: the fall wins and the counter clears.
- Reset asserted mid-frame clears everything immediately. The next frame is accepted only from a fresh start bit.
- All outputs are registered.

## Configuration
- `PS2_RX_EXTENDED_EN` defined: an E0-prefixed code `c` is formed as `{1'b1, c[6:0]}` for both make and break matching.
- `PS2_RX_EXTENDED_EN` undefined: E0-prefixed make and break codes are silently discarded (flags cleared, no `key_event`). `key_code[7]` is then only ever set by native codes ≥0x80 (0x83).

## Test plan
- Frame 0x1C (bits 0,00111000,p=0,stop 1) at 12.5 kHz -> `rx_byte`=0x1C with one `rx_valid` pulse; `key_code`=0x1C with one `key_event` pulse.
- 0x1C held, then F0 1C -> `key_code`=0x00 and one `key_event`. F0 1B instead -> `key_code` stays 0x1C, no event.
- 0x1C then 0x1B without break -> `key_code`=0x1B; a following F0 1C leaves 0x1B.
- Frame 0x1C with parity=1 -> `frame_err` pulse, no `rx_valid`, `key_code` unchanged. Same result for stop=0.
- `ps2_clk` stopped after 4 data bits for 100000 cycles -> `frame_err` pulse, FSM back in IDLE. Then a good 0x1C frame decodes.
- E0 75 -> `key_code`=0xF5 with the macro defined, unchanged without it. `reset_n` pulse mid-frame -> all outputs 0x00/0.
